ls_unit: RTL

Load/store sequencer between the core's execute stage and the byte-wide, 256-deep data memory. Accepts one memory request per handshake: byte and 16-bit little-endian loads/stores plus stack push/pop against an internal stack pointer. Splits 16-bit accesses into two sequential byte accesses and returns load data through a registered response. Drives the memory's address, write-data and write-enable directly and consumes its combinational read data.

---
 rtl/ls_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ls_unit.sv
// ls_unit: load/store sequencer between execute stage and a byte-wide,
// 256-deep data memory. 16-bit accesses are split into two byte accesses;
// PUSH/POP work against an internal downward-growing stack pointer.
//
// state | meaning
// IDLE  | accepting requests; memory port driven from the live request
// HI    | second byte of LH/SH in flight; memory port driven from latched context
module ls_unit #(
  parameter logic [7:0] STACK_TOP  = 8'hFF,
  parameter logic [7:0] STACK_BASE = 8'hC0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic [7:0]  reqAddr,
  input  logic [15:0] reqWdata,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic [7:0]  sp,
  output logic        stkOverflow,
  output logic        stkUnderflow,
  output logic [7:0]  memAddr,
  output logic [7:0]  memWdata,
  output logic        memWe,
  input  logic [7:0]  memRdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HI   = 1'b1;

  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_SB   = 3'b010;
  localparam logic [2:0] OP_LH   = 3'b011;
  localparam logic [2:0] OP_SH   = 3'b100;
  localparam logic [2:0] OP_PUSH = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b110;

  // Full means the byte just below STACK_BASE is the next free slot.
  localparam logic [7:0] SP_FULL = STACK_BASE - 8'd1;

  logic [0:0] state;
  logic [7:0] hi_addr;
  logic [7:0] hi_data;
  logic [7:0] lo_byte;
  logic       hi_store;
  logic       accept;
  logic       push_ok;
  logic       pop_ok;

  assign reqReady = (state == IDLE) && !reset;
  assign accept   = reqValid && reqReady;
  assign push_ok  = (sp != SP_FULL);
  assign pop_ok   = (sp != STACK_TOP);

  // Memory port: from latched second-byte context in HI, else from the accepted request.
  always_comb begin
    memAddr  = 8'h00;
    memWdata = 8'h00;
    memWe    = 1'b0;
    if (!reset) begin
      if (state == HI) begin
        memAddr  = hi_addr;
        memWdata = hi_data;
        memWe    = hi_store;
      end else if (accept) begin
        case (reqOp)
          OP_LB: memAddr = reqAddr;
          OP_SB: begin
            memAddr  = reqAddr;
            memWdata = reqWdata[7:0];
            memWe    = 1'b1;
          end
          OP_LH: memAddr = reqAddr;
          OP_SH: begin
            memAddr  = reqAddr;
            memWdata = reqWdata[7:0];
            memWe    = 1'b1;
          end
          OP_PUSH: begin
            if (push_ok) begin
              memAddr  = sp;
              memWdata = reqWdata[7:0];
              memWe    = 1'b1;
            end
          end
          OP_POP: begin
            if (pop_ok) memAddr = sp + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sequencer state, stack pointer, registered response and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sp           <= STACK_TOP;
      rspValid     <= 1'b0;
      rspData      <= 16'h0000;
      stkOverflow  <= 1'b0;
      stkUnderflow <= 1'b0;
      hi_addr      <= 8'h00;
      hi_data      <= 8'h00;
      lo_byte      <= 8'h00;
      hi_store     <= 1'b0;
    end else begin
      rspValid     <= 1'b0;
      stkOverflow  <= 1'b0;
      stkUnderflow <= 1'b0;
      if (state == HI) begin
        state <= IDLE;
        if (!hi_store) begin
          rspValid <= 1'b1;
          rspData  <= {memRdata, lo_byte};
        end
      end else if (accept) begin
        case (reqOp)
          OP_LB: begin
            rspValid <= 1'b1;
            rspData  <= {8'h00, memRdata};
          end
          OP_LH: begin
            lo_byte  <= memRdata;
            hi_addr  <= reqAddr + 8'd1;
            hi_store <= 1'b0;
            state    <= HI;
          end
          OP_SH: begin
            hi_addr  <= reqAddr + 8'd1;
            hi_data  <= reqWdata[15:8];
            hi_store <= 1'b1;
            state    <= HI;
          end
          OP_PUSH: begin
            if (push_ok) sp <= sp - 8'd1;
            else         stkOverflow <= 1'b1;
          end
          OP_POP: begin
            if (pop_ok) begin
              sp       <= sp + 8'd1;
              rspValid <= 1'b1;
              rspData  <= {8'h00, memRdata};
            end else begin
              stkUnderflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
